// File: rtl/std_gate_pkg.sv
// -----------------------------------------------------------------------------
// std_gate_pkg
// Shared constants for the standard gate library block.
//   DEFAULT_WIDTH : default AND/OR operand and result width
//   RST_BIT       : value every registered output bit takes while in reset
//   SEL_A / SEL_B : mux select encodings (SEL_A picks a_bit, SEL_B picks b_bit)
// -----------------------------------------------------------------------------
package std_gate_pkg;

    localparam int   DEFAULT_WIDTH = 32;

    localparam logic RST_BIT = 1'b0;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage : std_gate_pkg

// File: rtl/std_gate_reg.sv
// -----------------------------------------------------------------------------
// std_gate_reg
// Parameterised-width output register with asynchronous active-low clear and
// synchronous load enable.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear; q forced to all RST_BIT immediately
//   en    : load enable; q holds when low
//   d     : data to load
//   q     : registered data
// -----------------------------------------------------------------------------
module std_gate_reg
    import std_gate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    // The clear acts on the falling edge of rst_n itself, so a value loaded
    // just before reset is dropped without waiting for the next clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= {WIDTH{RST_BIT}};
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule : std_gate_reg

// File: rtl/std_gate_lib.sv
// -----------------------------------------------------------------------------
// std_gate_lib
// Standard gate library leaf: WIDTH-bit bitwise AND, WIDTH-bit bitwise OR and a
// 1-bit 2:1 mux, each available combinationally and through a one-cycle
// register stage.
// Ports:
//   clk     : rising-edge clock for the register stage
//   rst_n   : asynchronous active-low reset of the registered outputs only
//   en      : register-stage load enable (registered outputs hold when low)
//   a_vec   : AND/OR operand A
//   b_vec   : AND/OR operand B
//   a_bit   : mux data input A (selected when sel == SEL_A)
//   b_bit   : mux data input B (selected when sel == SEL_B)
//   sel     : mux select
//   and_out : combinational a_vec & b_vec
//   or_out  : combinational a_vec | b_vec
//   mux_out : combinational mux result
//   and_q   : registered and_out
//   or_q    : registered or_out
//   mux_q   : registered mux_out
// -----------------------------------------------------------------------------
module std_gate_lib
    import std_gate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a_vec,
    input  logic [WIDTH-1:0] b_vec,
    input  logic             a_bit,
    input  logic             b_bit,
    input  logic             sel,
    output logic [WIDTH-1:0] and_out,
    output logic [WIDTH-1:0] or_out,
    output logic             mux_out,
    output logic [WIDTH-1:0] and_q,
    output logic [WIDTH-1:0] or_q,
    output logic             mux_q
);

    // -------------------------------------------------------------------------
    // Combinational gates: strictly per bit, no cross-bit interaction.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign and_out[gi] = a_vec[gi] & b_vec[gi];
            assign or_out[gi]  = a_vec[gi] | b_vec[gi];
        end
    endgenerate

    // An unknown select falls through to the default arm and yields X rather
    // than silently favouring one input.
    always_comb begin
        mux_out = 1'bx;
        case (sel)
            SEL_A:   mux_out = a_bit;
            SEL_B:   mux_out = b_bit;
            default: mux_out = 1'bx;
        endcase
    end

    // -------------------------------------------------------------------------
    // Register stage: one instance per function, mux path is one bit wide.
    // -------------------------------------------------------------------------
    std_gate_reg #(
        .WIDTH (WIDTH)
    ) u_and_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d     (and_out),
        .q     (and_q)
    );

    std_gate_reg #(
        .WIDTH (WIDTH)
    ) u_or_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d     (or_out),
        .q     (or_q)
    );

    std_gate_reg #(
        .WIDTH (1)
    ) u_mux_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d     (mux_out),
        .q     (mux_q)
    );

endmodule : std_gate_lib

// File: tb/tb_std_gate_lib.sv
// -----------------------------------------------------------------------------
// tb_std_gate_lib
// Self-checking bench for std_gate_lib. A behavioural model keeps the expected
// registered values; combinational expectations come from plain bitwise
// arithmetic on the applied inputs.
// -----------------------------------------------------------------------------
module tb_std_gate_lib;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [W-1:0] a_vec;
    logic [W-1:0] b_vec;
    logic         a_bit;
    logic         b_bit;
    logic         sel;
    logic [W-1:0] and_out;
    logic [W-1:0] or_out;
    logic         mux_out;
    logic [W-1:0] and_q;
    logic [W-1:0] or_q;
    logic         mux_q;

    int total;
    int bad;

    // Model of the register stage.
    logic [W-1:0] m_and_q;
    logic [W-1:0] m_or_q;
    logic         m_mux_q;

    std_gate_lib #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .a_vec   (a_vec),
        .b_vec   (b_vec),
        .a_bit   (a_bit),
        .b_bit   (b_bit),
        .sel     (sel),
        .and_out (and_out),
        .or_out  (or_out),
        .mux_out (mux_out),
        .and_q   (and_q),
        .or_q    (or_q),
        .mux_q   (mux_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change #1 after a rising edge; outputs sampled #1 after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model update for one rising edge with the currently applied inputs.
    task automatic model_edge();
        if (rst_n && en) begin
            m_and_q = a_vec & b_vec;
            m_or_q  = a_vec | b_vec;
            m_mux_q = sel ? b_bit : a_bit;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        a_vec = 32'hFFFF_FFFF;
        b_vec = 32'hFFFF_FFFF;
        a_bit = 1'b1;
        b_bit = 1'b1;
        sel   = 1'b0;
        m_and_q = '0;
        m_or_q  = '0;
        m_mux_q = 1'b0;
        tick();
        tick();
        total++;
        if (and_q !== 32'h0 || or_q !== 32'h0 || mux_q !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: and_q=%h or_q=%h mux_q=%b required all zero",
                     and_q, or_q, mux_q);
        end
        total++;
        if (and_out !== 32'hFFFF_FFFF || or_out !== 32'hFFFF_FFFF || mux_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_comb: and_out=%h or_out=%h mux_out=%b required ffffffff ffffffff 1",
                     and_out, or_out, mux_out);
        end
        $display("reset: and_q=%h or_q=%h mux_q=%b", and_q, or_q, mux_q);
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        en    = 1'b1;
        a_vec = 32'h0;
        b_vec = 32'h0;
        #1;
        total++;
        if (and_out !== 32'h0 || or_out !== 32'h0) begin
            bad++;
            $display("FAIL zero_comb: and_out=%h or_out=%h required 0 0", and_out, or_out);
        end
        model_edge();
        tick();
        total++;
        if (and_q !== 32'h0 || or_q !== 32'h0) begin
            bad++;
            $display("FAIL zero_reg: and_q=%h or_q=%h required 0 0", and_q, or_q);
        end
        $display("zero: and_q=%h or_q=%h", and_q, or_q);
    endtask

    task automatic test_pattern();
        en    = 1'b1;
        a_vec = 32'hF0F0_A5A5;
        b_vec = 32'hFF00_FFFF;
        #1;
        total++;
        if (and_out !== 32'hF000_A5A5 || or_out !== 32'hFFF0_FFFF) begin
            bad++;
            $display("FAIL pattern_comb: and_out=%h or_out=%h required f000a5a5 fff0ffff",
                     and_out, or_out);
        end
        // Registered outputs must not have moved before the edge.
        total++;
        if (and_q !== 32'h0 || or_q !== 32'h0) begin
            bad++;
            $display("FAIL pattern_pre_edge: and_q=%h or_q=%h required 0 0", and_q, or_q);
        end
        model_edge();
        tick();
        total++;
        if (and_q !== 32'hF000_A5A5 || or_q !== 32'hFFF0_FFFF) begin
            bad++;
            $display("FAIL pattern_reg: and_q=%h or_q=%h required f000a5a5 fff0ffff",
                     and_q, or_q);
        end
        // OR with all-ones is all-ones regardless of the other operand.
        a_vec = 32'hFFFF_FFFF;
        b_vec = 32'h1234_5678;
        #1;
        total++;
        if (or_out !== 32'hFFFF_FFFF || and_out !== 32'h1234_5678) begin
            bad++;
            $display("FAIL ones_comb: or_out=%h and_out=%h required ffffffff 12345678",
                     or_out, and_out);
        end
        model_edge();
        tick();
        $display("pattern: and_q=%h or_q=%h", and_q, or_q);
    endtask

    task automatic test_mux();
        logic [2:0] tbl [3];
        logic       want [3];
        tbl[0] = 3'b100; want[0] = 1'b1;  // a_bit=1 b_bit=0 sel=0
        tbl[1] = 3'b101; want[1] = 1'b0;  // a_bit=1 b_bit=0 sel=1
        tbl[2] = 3'b011; want[2] = 1'b1;  // a_bit=0 b_bit=1 sel=1
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_bit = tbl[i][2];
            b_bit = tbl[i][1];
            sel   = tbl[i][0];
            #1;
            total++;
            if (mux_out !== want[i]) begin
                bad++;
                $display("FAIL mux_comb_%0d: mux_out=%b required %b", i, mux_out, want[i]);
            end
            model_edge();
            tick();
            total++;
            if (mux_q !== want[i]) begin
                bad++;
                $display("FAIL mux_reg_%0d: mux_q=%b required %b", i, mux_q, want[i]);
            end
            $display("mux %0d: a=%b b=%b sel=%b mux_out=%b mux_q=%b",
                     i, a_bit, b_bit, sel, mux_out, mux_q);
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] h_and;
        logic [W-1:0] h_or;
        logic         h_mux;
        en    = 1'b1;
        a_vec = 32'hDEAD_BEEF;
        b_vec = 32'h0F0F_F0F0;
        a_bit = 1'b0;
        b_bit = 1'b1;
        sel   = 1'b1;
        model_edge();
        tick();
        h_and = 32'hDEAD_BEEF & 32'h0F0F_F0F0;
        h_or  = 32'hDEAD_BEEF | 32'h0F0F_F0F0;
        h_mux = 1'b1;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_vec = $urandom;
            b_vec = $urandom;
            a_bit = ~a_bit;
            sel   = 1'b0;
            #1;
            total++;
            if (and_out !== (a_vec & b_vec) || or_out !== (a_vec | b_vec) || mux_out !== a_bit) begin
                bad++;
                $display("FAIL hold_comb_%0d: and_out=%h or_out=%h mux_out=%b required %h %h %b",
                         i, and_out, or_out, mux_out, a_vec & b_vec, a_vec | b_vec, a_bit);
            end
            model_edge();
            tick();
            total++;
            if (and_q !== h_and || or_q !== h_or || mux_q !== h_mux) begin
                bad++;
                $display("FAIL hold_reg_%0d: and_q=%h or_q=%h mux_q=%b required %h %h %b",
                         i, and_q, or_q, mux_q, h_and, h_or, h_mux);
            end
            $display("hold %0d: and_q=%h or_q=%h mux_q=%b", i, and_q, or_q, mux_q);
        end
    endtask

    task automatic test_async_reset();
        en    = 1'b1;
        a_vec = 32'hFFFF_FFFF;
        b_vec = 32'hFFFF_FFFF;
        a_bit = 1'b1;
        b_bit = 1'b0;
        sel   = 1'b0;
        model_edge();
        tick();
        total++;
        if (and_q !== 32'hFFFF_FFFF || mux_q !== 1'b1) begin
            bad++;
            $display("FAIL areset_load: and_q=%h mux_q=%b required ffffffff 1", and_q, mux_q);
        end
        // Assert reset mid-cycle, well away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (and_q !== 32'h0 || or_q !== 32'h0 || mux_q !== 1'b0) begin
            bad++;
            $display("FAIL areset_immediate: and_q=%h or_q=%h mux_q=%b required 0 0 0",
                     and_q, or_q, mux_q);
        end
        m_and_q = '0;
        m_or_q  = '0;
        m_mux_q = 1'b0;
        tick();
        total++;
        if (and_q !== 32'h0 || or_q !== 32'h0 || mux_q !== 1'b0) begin
            bad++;
            $display("FAIL areset_edge: and_q=%h or_q=%h mux_q=%b required 0 0 0",
                     and_q, or_q, mux_q);
        end
        #2;
        rst_n = 1'b1;
        a_vec = 32'hA5A5_5A5A;
        b_vec = 32'hFFFF_0000;
        model_edge();
        tick();
        total++;
        if (and_q !== 32'hA5A5_0000 || or_q !== 32'hFFFF_5A5A || mux_q !== 1'b1) begin
            bad++;
            $display("FAIL areset_reload: and_q=%h or_q=%h mux_q=%b required a5a50000 ffff5a5a 1",
                     and_q, or_q, mux_q);
        end
        $display("async reset: reload and_q=%h or_q=%h mux_q=%b", and_q, or_q, mux_q);
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            a_vec = $urandom;
            b_vec = $urandom;
            a_bit = 1'($urandom_range(0, 1));
            b_bit = 1'($urandom_range(0, 1));
            sel   = 1'($urandom_range(0, 1));
            en    = ($urandom_range(0, 3) != 0);
            if ((i % 100) == 0) begin
                a_vec = (i % 200 == 0) ? 32'h0 : 32'hFFFF_FFFF;
            end
            #1;
            total++;
            if (and_out !== (a_vec & b_vec) || or_out !== (a_vec | b_vec) ||
                mux_out !== (sel ? b_bit : a_bit)) begin
                bad++;
                errs++;
                $display("FAIL rand_comb_%0d: and_out=%h or_out=%h mux_out=%b required %h %h %b",
                         i, and_out, or_out, mux_out, a_vec & b_vec, a_vec | b_vec,
                         sel ? b_bit : a_bit);
            end
            model_edge();
            tick();
            total++;
            if (and_q !== m_and_q || or_q !== m_or_q || mux_q !== m_mux_q) begin
                bad++;
                errs++;
                $display("FAIL rand_reg_%0d: and_q=%h or_q=%h mux_q=%b required %h %h %b",
                         i, and_q, or_q, mux_q, m_and_q, m_or_q, m_mux_q);
            end
            $display("rand %0d: en=%b a=%h b=%h and_q=%h or_q=%h mux_q=%b",
                     i, en, a_vec, b_vec, and_q, or_q, mux_q);
        end
        $display("random sweep: 1000 vectors, %0d errors", errs);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_zero();
        test_pattern();
        test_mux();
        test_hold();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_std_gate_lib
